// File: rtl/mmio_settle_monitor.sv
// mmio_settle_monitor: snoops stores to MMIO output registers and checks that
// each observed output port settles to the stored (masked) value in MAX_LAT cycles.
// Ports:
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_clr                  clear counters, sticky flags and first-error snapshot
//   i_en                   arm enable for new stores
//   i_st_vld/addr/wdata    store bus snoop
//   i_obs                  observed ports, channel i in slice i
//   o_busy                 channel checker waiting for a match
//   o_err_sticky           channel timed out since reset/clear
//   o_pass_pulse/err_pulse registered one-cycle completion pulses
//   o_pass_cnt/err_cnt     saturating totals
//   o_first_err_*          snapshot of the first timeout
module mmio_settle_monitor #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter logic [NUM_CH*ADDR_W-1:0] CH_ADDR =
        {32'h7024, 32'h7020, 32'h7010, 32'h7000},
    parameter logic [NUM_CH*DATA_W-1:0] CH_MASK =
        {32'h7F7F7F7F, 32'h7F7F7F7F, 32'hFFFFFFFF, 32'hFFFFFFFF},
    parameter int MAX_LAT = 4,
    parameter int CNT_W = 16,
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_clr,
    input  logic                     i_en,
    input  logic                     i_st_vld,
    input  logic [ADDR_W-1:0]        i_st_addr,
    input  logic [DATA_W-1:0]        i_st_wdata,
    input  logic [NUM_CH*DATA_W-1:0] i_obs,
    output logic [NUM_CH-1:0]        o_busy,
    output logic [NUM_CH-1:0]        o_err_sticky,
    output logic [NUM_CH-1:0]        o_pass_pulse,
    output logic [NUM_CH-1:0]        o_err_pulse,
    output logic [CNT_W-1:0]         o_pass_cnt,
    output logic [CNT_W-1:0]         o_err_cnt,
    output logic                     o_first_err_vld,
    output logic [CH_W-1:0]          o_first_err_ch,
    output logic [DATA_W-1:0]        o_first_err_exp,
    output logic [DATA_W-1:0]        o_first_err_obs
);

    // Popcount of up to 16 same-edge events fits in 5 bits.
    localparam int PC_W = 5;

    typedef enum logic {S_IDLE, S_WAIT} st_t;

    st_t               st_q  [NUM_CH];
    st_t               st_d  [NUM_CH];
    logic [DATA_W-1:0] exp_q [NUM_CH];
    logic [DATA_W-1:0] exp_d [NUM_CH];
    logic [7:0]        age_q [NUM_CH];
    logic [7:0]        age_d [NUM_CH];
    logic [DATA_W-1:0] obs_m [NUM_CH];
    logic [NUM_CH-1:0] arm;
    logic [NUM_CH-1:0] pass_ev;
    logic [NUM_CH-1:0] err_ev;

    logic              fe_hit;
    logic [CH_W-1:0]   fe_ch;
    logic [DATA_W-1:0] fe_exp;
    logic [DATA_W-1:0] fe_obs;

    function automatic logic [PC_W-1:0] popc(input logic [NUM_CH-1:0] v);
        logic [PC_W-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_CH; i++) c = c + PC_W'(v[i]);
        return c;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(
        input logic [CNT_W-1:0] a,
        input logic [PC_W-1:0]  b
    );
        logic [CNT_W+PC_W-1:0] s;
        s = (CNT_W+PC_W)'(a) + (CNT_W+PC_W)'(b);
        if (s > (CNT_W+PC_W)'({CNT_W{1'b1}})) return '1;
        return s[CNT_W-1:0];
    endfunction

    // Completion is evaluated before arming so a completion on the
    // re-arm edge is still recorded, and the new check overrides state.
    always_comb begin
        arm     = '0;
        pass_ev = '0;
        err_ev  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            obs_m[i] = i_obs[i*DATA_W +: DATA_W]
                     & CH_MASK[i*DATA_W +: DATA_W];
            arm[i]   = i_en & i_st_vld
                     & (i_st_addr == CH_ADDR[i*ADDR_W +: ADDR_W]);
            st_d[i]  = st_q[i];
            exp_d[i] = exp_q[i];
            age_d[i] = age_q[i];
            case (st_q[i])
                S_WAIT: begin
                    if (obs_m[i] == exp_q[i]) begin
                        pass_ev[i] = 1'b1;
                        st_d[i]    = S_IDLE;
                    end else if (age_q[i] == 8'(MAX_LAT - 1)) begin
                        err_ev[i] = 1'b1;
                        st_d[i]   = S_IDLE;
                    end else begin
                        age_d[i] = age_q[i] + 8'd1;
                    end
                end
                default: ;
            endcase
            if (arm[i]) begin
                st_d[i]  = S_WAIT;
                exp_d[i] = i_st_wdata & CH_MASK[i*DATA_W +: DATA_W];
                age_d[i] = '0;
            end
        end
    end

    // Descending scan so the lowest timed-out channel wins.
    always_comb begin
        fe_hit = |err_ev;
        fe_ch  = '0;
        fe_exp = '0;
        fe_obs = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (err_ev[i]) begin
                fe_ch  = CH_W'(i);
                fe_exp = exp_q[i];
                fe_obs = obs_m[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) o_busy[i] = (st_q[i] == S_WAIT);
    end

    always_ff @(posedge i_clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (i_rst) begin
                st_q[i]  <= S_IDLE;
                exp_q[i] <= '0;
                age_q[i] <= '0;
            end else begin
                st_q[i]  <= st_d[i];
                exp_q[i] <= exp_d[i];
                age_q[i] <= age_d[i];
            end
        end
    end

    // Clear drops same-edge events but leaves the checkers running.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            o_pass_pulse    <= '0;
            o_err_pulse     <= '0;
            o_err_sticky    <= '0;
            o_pass_cnt      <= '0;
            o_err_cnt       <= '0;
            o_first_err_vld <= 1'b0;
            o_first_err_ch  <= '0;
            o_first_err_exp <= '0;
            o_first_err_obs <= '0;
        end else begin
            o_pass_pulse <= pass_ev;
            o_err_pulse  <= err_ev;
            o_err_sticky <= o_err_sticky | err_ev;
            o_pass_cnt   <= sat_add(o_pass_cnt, popc(pass_ev));
            o_err_cnt    <= sat_add(o_err_cnt, popc(err_ev));
            if (!o_first_err_vld && fe_hit) begin
                o_first_err_vld <= 1'b1;
                o_first_err_ch  <= fe_ch;
                o_first_err_exp <= fe_exp;
                o_first_err_obs <= fe_obs;
            end
        end
    end

endmodule

// File: tb/tb_mmio_settle_monitor.sv
// tb_mmio_settle_monitor: directed and random stimulus against a
// deadline-based reference model of the settle monitor.
module tb_mmio_settle_monitor;

    localparam int NCH  = 4;
    localparam int LAT  = 4;
    localparam int CW   = 4;
    localparam int CMAX = 15;

    logic [31:0] adr_t [NCH] = '{32'h7000, 32'h7010, 32'h7020, 32'h7024};
    logic [31:0] msk_t [NCH] = '{32'hFFFFFFFF, 32'hFFFFFFFF,
                                 32'h7F7F7F7F, 32'h7F7F7F7F};

    logic          clk = 1'b0;
    logic          rst, clr, en, vld;
    logic [31:0]   addr, wdata;
    logic [127:0]  obs;
    logic [3:0]    o_busy, o_err_sticky, o_pass_pulse, o_err_pulse;
    logic [CW-1:0] o_pass_cnt, o_err_cnt;
    logic          o_first_err_vld;
    logic [1:0]    o_first_err_ch;
    logic [31:0]   o_first_err_exp, o_first_err_obs;

    int n_asrt = 0;
    int n_fail = 0;

    // Reference model: each armed channel has an absolute deadline edge.
    bit          m_arm [NCH];
    logic [31:0] m_exp [NCH];
    int          m_dl  [NCH];
    int          edge_n = 0;
    logic [3:0]  e_busy, e_sticky, e_pp, e_ep;
    int          e_pcnt, e_ecnt, e_fch;
    bit          e_fvld;
    logic [31:0] e_fexp, e_fobs;

    always #5 clk = ~clk;

    mmio_settle_monitor #(.CNT_W(CW)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_clr           (clr),
        .i_en            (en),
        .i_st_vld        (vld),
        .i_st_addr       (addr),
        .i_st_wdata      (wdata),
        .i_obs           (obs),
        .o_busy          (o_busy),
        .o_err_sticky    (o_err_sticky),
        .o_pass_pulse    (o_pass_pulse),
        .o_err_pulse     (o_err_pulse),
        .o_pass_cnt      (o_pass_cnt),
        .o_err_cnt       (o_err_cnt),
        .o_first_err_vld (o_first_err_vld),
        .o_first_err_ch  (o_first_err_ch),
        .o_first_err_exp (o_first_err_exp),
        .o_first_err_obs (o_first_err_obs)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] want);
        n_asrt++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic model_edge();
        logic [3:0]  pe, ee;
        logic [31:0] om;
        int          fi;
        logic [31:0] fx, fo;
        edge_n++;
        pe = '0;
        ee = '0;
        fi = -1;
        fx = '0;
        fo = '0;
        if (rst) begin
            for (int c = 0; c < NCH; c++) m_arm[c] = 1'b0;
            e_sticky = '0; e_pp = '0; e_ep = '0;
            e_pcnt = 0; e_ecnt = 0; e_fvld = 1'b0;
            e_fch = 0; e_fexp = '0; e_fobs = '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                om = obs[c*32 +: 32] & msk_t[c];
                if (m_arm[c]) begin
                    if (om == m_exp[c]) begin
                        pe[c] = 1'b1;
                        m_arm[c] = 1'b0;
                    end else if (edge_n == m_dl[c]) begin
                        ee[c] = 1'b1;
                        m_arm[c] = 1'b0;
                        if (fi < 0) begin
                            fi = c; fx = m_exp[c]; fo = om;
                        end
                    end
                end
            end
            for (int c = 0; c < NCH; c++) begin
                if (en && vld && addr == adr_t[c]) begin
                    m_arm[c] = 1'b1;
                    m_exp[c] = wdata & msk_t[c];
                    m_dl[c]  = edge_n + LAT;
                end
            end
            if (clr) begin
                e_sticky = '0; e_pp = '0; e_ep = '0;
                e_pcnt = 0; e_ecnt = 0; e_fvld = 1'b0;
                e_fch = 0; e_fexp = '0; e_fobs = '0;
            end else begin
                e_pp = pe;
                e_ep = ee;
                e_sticky = e_sticky | ee;
                e_pcnt = sat(e_pcnt + $countones(pe));
                e_ecnt = sat(e_ecnt + $countones(ee));
                if (!e_fvld && fi >= 0) begin
                    e_fvld = 1'b1; e_fch = fi; e_fexp = fx; e_fobs = fo;
                end
            end
        end
        for (int c = 0; c < NCH; c++) e_busy[c] = m_arm[c];
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check("busy", 64'(o_busy), 64'(e_busy));
        check("sticky", 64'(o_err_sticky), 64'(e_sticky));
        check("pass_pulse", 64'(o_pass_pulse), 64'(e_pp));
        check("err_pulse", 64'(o_err_pulse), 64'(e_ep));
        check("pass_cnt", 64'(o_pass_cnt), 64'(e_pcnt));
        check("err_cnt", 64'(o_err_cnt), 64'(e_ecnt));
        check("fe_vld", 64'(o_first_err_vld), 64'(e_fvld));
        check("fe_ch", 64'(o_first_err_ch), 64'(e_fch));
        check("fe_exp", 64'(o_first_err_exp), 64'(e_fexp));
        check("fe_obs", 64'(o_first_err_obs), 64'(e_fobs));
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d);
        vld = 1'b1; addr = a; wdata = d;
    endtask

    task automatic nost();
        vld = 1'b0; addr = 32'h0; wdata = 32'h0;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; en = 1'b0;
        vld = 1'b0; addr = '0; wdata = '0; obs = '0;
        for (int c = 0; c < NCH; c++) begin
            m_arm[c] = 1'b0; m_exp[c] = '0; m_dl[c] = 0;
        end
        tick();
        tick();
        check("rst_busy", 64'(o_busy), 64'h0);
        check("rst_cnt", 64'(o_pass_cnt), 64'h0);
        rst = 1'b0;
        en = 1'b1;

        // Pass on channel 0 two edges after the store.
        st(32'h7000, 32'h1);
        tick();
        nost();
        tick();
        check("t1_busy", 64'(o_busy), 64'h1);
        obs[31:0] = 32'h1;
        tick();
        check("t1_pass", 64'(o_pass_pulse), 64'h1);
        check("t1_pcnt", 64'(o_pass_cnt), 64'h1);
        check("t1_ecnt", 64'(o_err_cnt), 64'h0);

        // Masked pass, then timeout on channel 2.
        obs[95:64] = 32'h88848281;
        st(32'h7020, 32'h08040201);
        tick();
        nost();
        tick();
        check("t2_pass", 64'(o_pass_pulse), 64'h4);
        obs[95:64] = 32'h0;
        st(32'h7020, 32'h08040201);
        tick();
        nost();
        tick();
        tick();
        tick();
        check("t2_early", 64'(o_err_pulse), 64'h0);
        tick();
        check("t2_err", 64'(o_err_pulse), 64'h4);
        check("t2_sticky", 64'(o_err_sticky), 64'h4);
        check("t2_fch", 64'(o_first_err_ch), 64'h2);
        check("t2_fexp", 64'(o_first_err_exp), 64'h08040201);
        check("t2_fobs", 64'(o_first_err_obs), 64'h0);

        // Re-arm abandons the first check on channel 1.
        st(32'h7010, 32'h2);
        tick();
        nost();
        tick();
        tick();
        st(32'h7010, 32'h3);
        tick();
        nost();
        obs[63:32] = 32'h2;
        tick();
        tick();
        tick();
        check("t3_early", 64'(o_err_pulse), 64'h0);
        tick();
        check("t3_err", 64'(o_err_pulse), 64'h2);
        check("t3_ecnt", 64'(o_err_cnt), 64'h2);

        // Clear, then snapshot holds the first of two timeouts.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("t4_clr_vld", 64'(o_first_err_vld), 64'h0);
        st(32'h7024, 32'h5);
        tick();
        nost();
        repeat (4) tick();
        check("t4_fch3", 64'(o_first_err_ch), 64'h3);
        obs[31:0] = 32'h0;
        st(32'h7000, 32'h9);
        tick();
        nost();
        repeat (4) tick();
        check("t4_fch_hold", 64'(o_first_err_ch), 64'h3);
        check("t4_sticky", 64'(o_err_sticky), 64'h9);

        // Saturation, then clear during an in-flight check.
        for (int k = 0; k < 17; k++) begin
            obs[31:0] = 32'(k + 16);
            st(32'h7000, 32'(k + 16));
            tick();
            nost();
            tick();
        end
        check("t5_sat", 64'(o_pass_cnt), 64'(CMAX));
        obs[31:0] = 32'h0;
        st(32'h7000, 32'h55);
        tick();
        nost();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("t5_clr_cnt", 64'(o_pass_cnt), 64'h0);
        check("t5_inflight", 64'(o_busy), 64'h1);
        obs[31:0] = 32'h55;
        tick();
        check("t5_pass", 64'(o_pass_pulse), 64'h1);

        // Reset mid-check and disabled arm.
        obs[31:0] = 32'h0;
        st(32'h7000, 32'h7);
        tick();
        nost();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_busy", 64'(o_busy), 64'h0);
        obs[31:0] = 32'h7;
        tick();
        check("t6_nopulse", 64'(o_pass_pulse), 64'h0);
        en = 1'b0;
        st(32'h7000, 32'h1);
        tick();
        check("t6_noarm", 64'(o_busy), 64'h0);
        nost();
        en = 1'b1;

        // Random traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            int r;
            vld = 1'($urandom % 2);
            r = int'($urandom % 5);
            addr = (r < NCH) ? adr_t[r] : 32'h7004 + 32'($urandom % 4) * 4;
            wdata = ($urandom % 4) | ((($urandom % 4) == 0) ? 32'h80 : 32'h0);
            for (int c = 0; c < NCH; c++) begin
                if (($urandom % 3) == 0)
                    obs[c*32 +: 32] = ($urandom % 4)
                        | ((($urandom % 4) == 0) ? 32'h80 : 32'h0);
            end
            en  = (($urandom % 10) != 0);
            clr = (($urandom % 60) == 0);
            rst = (($urandom % 150) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asrt, n_fail);
        $finish;
    end

endmodule
